seq_append: RTL and testbench

SEQ_APPEND -- requirements
Module: seq_append

---
 rtl/seq_append_pkg.sv | 12 +
 rtl/axis_reg_slice.sv | 65 ++++++
 rtl/seq_append.sv | 113 +++++++++++
 tb/tb_seq_append.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_append_pkg.sv
// Shared types and defaults for the seq_append stream trailer block.
package seq_append_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_TRAILER = 2'd2
  } state_e;

  localparam int SEQ_INIT_DEFAULT = 1;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream skid slice: fully registered outputs, s_ready driven only from flops.
module axis_reg_slice #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  logic              en_q, en_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              s_fire;

  // en_q holds ready low for one cycle after reset so the upstream sees a clean start.
  assign s_ready = en_q & ~skid_valid_q;
  assign s_fire  = s_valid & s_ready;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  always_comb begin
    en_d         = 1'b1;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || m_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_fire;
        if (s_fire) out_data_d = s_data;
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      en_q         <= en_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/seq_append.sv
// Appends a sequence-number trailer beat to AXI-Stream frames when ctrl_seq_en is set.
// Define SEQ_APPEND_STATS_EN to add the stat_frames counter port.
module seq_append
  import seq_append_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SEQ_W    = 16,
  parameter int SEQ_INIT = SEQ_INIT_DEFAULT
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_areset,
  input  logic              ctrl_seq_en,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
`ifdef SEQ_APPEND_STATS_EN
  ,
  output logic [31:0]       stat_frames
`endif
);

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              frame_en;
  logic [DATA_W-1:0] trailer;
  logic              slice_valid;
  logic              slice_ready;
  logic [DATA_W:0]   slice_data;
  logic [DATA_W:0]   slice_m_data;

  // The enable is taken live on the first beat of a frame and latched for the rest of it.
  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    seq_d         = seq_q;
    trailer       = '0;
    trailer[SEQ_W-1:0] = seq_q;
    frame_en      = (state_q == S_IDLE) ? ctrl_seq_en : en_q;
    slice_valid   = s_axis_tvalid;
    slice_data    = {s_axis_tlast & ~frame_en, s_axis_tdata};
    s_axis_tready = slice_ready;
    case (state_q)
      S_IDLE, S_DATA: begin
        if (s_axis_tvalid && slice_ready) begin
          en_d = frame_en;
          if (!s_axis_tlast)  state_d = S_DATA;
          else if (frame_en)  state_d = S_TRAILER;
          else                state_d = S_IDLE;
        end
      end
      S_TRAILER: begin
        slice_valid   = 1'b1;
        slice_data    = {1'b1, trailer};
        s_axis_tready = 1'b0;
        if (slice_ready) begin
          seq_d   = (seq_q == '1) ? SEQ_W'(SEQ_INIT) : seq_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      seq_q   <= SEQ_W'(SEQ_INIT);
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      seq_q   <= seq_d;
    end
  end

  axis_reg_slice #(
    .DATA_W(DATA_W + 1)
  ) u_slice (
    .clk     (m_axis_aclk),
    .reset   (m_axis_areset),
    .s_valid (slice_valid),
    .s_data  (slice_data),
    .s_ready (slice_ready),
    .m_valid (m_axis_tvalid),
    .m_data  (slice_m_data),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tdata} = slice_m_data;

`ifdef SEQ_APPEND_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;

  always_comb begin
    stat_frames_d = stat_frames_q;
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) stat_frames_d = stat_frames_q + 32'd1;
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) stat_frames_q <= '0;
    else               stat_frames_q <= stat_frames_d;
  end

  assign stat_frames = stat_frames_q;
`endif

endmodule

// File: tb/tb_seq_append.sv
// Scoreboard bench for seq_append: random frames against a frame-level reference model.
module tb_seq_append;

  localparam int DATA_W   = 32;
  localparam int SEQ_W    = 16;
  localparam int SEQ_INIT = 1;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ctrl_seq_en;
  logic              s_tvalid, s_tlast, s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [DATA_W-1:0] m_tdata;

  logic       w_ctrl, w_s_tvalid, w_s_tlast, w_s_tready;
  logic [7:0] w_s_tdata, w_m_tdata;
  logic       w_m_tvalid, w_m_tlast;
  logic       w_m_tready = 1'b1;

`ifdef SEQ_APPEND_STATS_EN
  logic [31:0] stat_frames, w_stat_frames;
`endif

  seq_append #(.DATA_W(DATA_W), .SEQ_W(SEQ_W), .SEQ_INIT(SEQ_INIT)) u_dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (reset),
    .ctrl_seq_en   (ctrl_seq_en),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
`ifdef SEQ_APPEND_STATS_EN
    ,.stat_frames  (stat_frames)
`endif
  );

  // Narrow instance used to exercise counter wrap in a handful of frames.
  seq_append #(.DATA_W(8), .SEQ_W(2), .SEQ_INIT(1)) u_dut_wrap (
    .m_axis_aclk   (clk),
    .m_axis_areset (reset),
    .ctrl_seq_en   (w_ctrl),
    .s_axis_tvalid (w_s_tvalid),
    .s_axis_tdata  (w_s_tdata),
    .s_axis_tlast  (w_s_tlast),
    .s_axis_tready (w_s_tready),
    .m_axis_tvalid (w_m_tvalid),
    .m_axis_tdata  (w_m_tdata),
    .m_axis_tlast  (w_m_tlast),
    .m_axis_tready (w_m_tready)
`ifdef SEQ_APPEND_STATS_EN
    ,.stat_frames  (w_stat_frames)
`endif
  );

  beat_t       exp_q[$];
  beat_t       w_q[$];
  logic [31:0] frame_q[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          seq_model;
  int          stat_model;
  bit          rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Downstream ready: always high, or a fair coin per cycle in the stress phases.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Main monitor: pops expectations on every transfer and checks stalled outputs stay put.
  logic        held = 1'b0;
  logic [32:0] held_val;
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("stall_valid", 64'(m_tvalid), 64'd1);
        checkOutput("stall_data", 64'({m_tlast, m_tdata}), 64'(held_val));
      end
      held = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'({m_tlast, m_tdata}), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          checkOutput("m_beat", 64'({m_tlast, m_tdata}), 64'(e));
        end
      end else if (m_tvalid) begin
        held     = 1'b1;
        held_val = {m_tlast, m_tdata};
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!reset && w_m_tvalid) begin
      if (w_q.size() == 0) begin
        checkOutput("wrap_unexpected_beat", 64'({w_m_tlast, w_m_tdata}), 64'hDEAD);
      end else begin
        e = w_q.pop_front();
        checkOutput("wrap_beat", 64'({w_m_tlast, 24'd0, w_m_tdata}), 64'(e));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Bounded wait for the DUT to accept the beat currently presented; returns at posedge+1.
  task automatic waitAccept();
    int t = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      t++;
      if (t > 500) begin
        checkOutput("accept_timeout", 64'(s_tready), 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int nextSeq(input int s);
    return (s == (1 << SEQ_W) - 1) ? SEQ_INIT : s + 1;
  endfunction

  // Sends frame_q as one frame; the model says payload keeps tlast only when the trailer is off.
  task automatic applyStimulus(input bit en, input bit gaps, input bit toggle);
    int n = frame_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back({!en && (i == n - 1), frame_q[i]});
    if (en) begin
      exp_q.push_back({1'b1, 32'(seq_model)});
      seq_model = nextSeq(seq_model);
    end
    stat_model++;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = frame_q[i];
      s_tlast  = (i == n - 1);
      if (i == 0)      ctrl_seq_en = en;
      else if (toggle) ctrl_seq_en = 1'($urandom_range(0, 1));
      waitAccept();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic randomFrame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back($urandom);
  endtask

  task automatic applyReset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    w_q.delete();
    seq_model  = SEQ_INIT;
    stat_model = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((exp_q.size() != 0 || w_q.size() != 0 || m_tvalid || w_m_tvalid) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    checkOutput("drain_left", 64'(exp_q.size() + w_q.size()), 64'd0);
  endtask

  // Reset lands in the cycle after the 2nd beat of a 4-beat enabled frame.
  task automatic midResetTest();
    randomFrame(4);
    exp_q.push_back({1'b0, frame_q[0]});
    exp_q.push_back({1'b0, frame_q[1]});
    for (int i = 0; i < 2; i++) begin
      s_tvalid    = 1'b1;
      s_tdata     = frame_q[i];
      s_tlast     = 1'b0;
      ctrl_seq_en = 1'b1;
      waitAccept();
    end
    reset    = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    seq_model  = SEQ_INIT;
    stat_model = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wrap_exp[5] = '{1, 2, 3, 1, 2};
    logic [7:0] wd;

    reset       = 1'b1;
    ctrl_seq_en = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    w_ctrl      = 1'b1;
    w_s_tvalid  = 1'b0;
    w_s_tdata   = '0;
    w_s_tlast   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
    checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst_m_tdata", 64'(m_tdata), 64'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    seq_model  = SEQ_INIT;
    stat_model = 0;
    @(negedge clk);
    checkOutput("post_rst_s_tready", 64'(s_tready), 64'd0);
    checkOutput("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s_tready_rise", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] disabled frame, then enabled frames A,B,C");
    frame_q = {32'h0000_0011, 32'h0000_0022};
    applyStimulus(1'b0, 1'b0, 1'b0);
    frame_q = {32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
    applyStimulus(1'b1, 1'b0, 1'b0);
    randomFrame(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    frame_q = {32'h0000_0077};
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] reset in the middle of a frame");
    midResetTest();
    randomFrame(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] 100 enabled frames with random backpressure");
    applyReset();
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      randomFrame($urandom_range(1, 5));
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    waitDrain();

    $display("[TB] mixed enable with mid-frame ctrl toggling");
    for (int f = 0; f < 40; f++) begin
      randomFrame($urandom_range(1, 4));
      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    waitDrain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] 2-bit counter wrap on narrow instance");
    for (int k = 0; k < 5; k++) begin
      wd = 8'($urandom);
      w_q.push_back({1'b0, 24'd0, wd});
      w_q.push_back({1'b1, 32'(wrap_exp[k])});
      w_s_tvalid = 1'b1;
      w_s_tdata  = wd;
      w_s_tlast  = 1'b1;
      begin
        int t = 0;
        forever begin
          @(negedge clk);
          if (w_s_tready) break;
          t++;
          if (t > 500) begin
            checkOutput("wrap_accept_timeout", 64'(w_s_tready), 64'd1);
            break;
          end
          @(posedge clk);
          #1;
        end
      end
      @(posedge clk);
      #1;
      w_s_tvalid = 1'b0;
    end
    waitDrain();

`ifdef SEQ_APPEND_STATS_EN
    $display("[TB] frame statistics");
    applyReset();
    for (int f = 0; f < 7; f++) begin
      randomFrame($urandom_range(1, 3));
      applyStimulus(f % 2 == 0, 1'b0, 1'b0);
    end
    waitDrain();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stat_frames", 64'(stat_frames), 64'(stat_model));
    checkOutput("stat_frames_seven", 64'(stat_frames), 64'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
